// File: rtl/bless_alloc_pkg.sv
// Shared port encoding and XY routing helpers for the BLESS deflection allocator.
package bless_alloc_pkg;

    localparam int P_N = 0;
    localparam int P_S = 1;
    localparam int P_E = 2;
    localparam int P_W = 3;
    localparam int P_I = 4;

    typedef logic [4:0] port_t;

    function automatic port_t xy_route(input logic [15:0] dst_x, input logic [15:0] dst_y,
                                       input logic [15:0] my_x,  input logic [15:0] my_y);
        port_t p;
        p = '0;
        if (dst_x > my_x)      p[P_E] = 1'b1;
        else if (dst_x < my_x) p[P_W] = 1'b1;
        else if (dst_y > my_y) p[P_N] = 1'b1;
        else if (dst_y < my_y) p[P_S] = 1'b1;
        else                   p[P_I] = 1'b1;
        return p;
    endfunction

    // Lowest free network output (n,s,e,w order); the eject port is never a deflection target.
    function automatic port_t first_free(input port_t free);
        port_t p;
        p = '0;
        for (int k = P_W; k >= P_N; k--) begin
            if (free[k]) p = port_t'(5'b00001 << k);
        end
        return p;
    endfunction

endpackage

// File: rtl/bless_route_calc.sv
// Productive XY output for one flit destination {y,x}.
module bless_route_calc
    import bless_alloc_pkg::*;
#(
    parameter int ADDRBITS2 = 8,
    parameter int MY_X      = 0,
    parameter int MY_Y      = 0
) (
    input  logic [ADDRBITS2/2-1:0] i_dst,
    output port_t                  o_port
);

    localparam int CW = ADDRBITS2 / 4;

    logic [15:0] w_x;
    logic [15:0] w_y;

    assign w_x    = 16'(i_dst[CW-1:0]);
    assign w_y    = 16'(i_dst[2*CW-1:CW]);
    assign o_port = xy_route(w_x, w_y, 16'(MY_X), 16'(MY_Y));

endmodule

// File: rtl/bless_port_alloc.sv
// BLESS deflection port allocator: oldest-first network allocation, then injection,
// with one register stage aligned to the crossbar datapath.
module bless_port_alloc
    import bless_alloc_pkg::*;
#(
    parameter int HOPBITS    = 8,
    parameter int ADDRBITS2  = 8,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int STARVE_LIM = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld_n,
    input  logic                 vld_s,
    input  logic                 vld_e,
    input  logic                 vld_w,
    input  logic [ADDRBITS2-1:0] srcdst_n,
    input  logic [ADDRBITS2-1:0] srcdst_s,
    input  logic [ADDRBITS2-1:0] srcdst_e,
    input  logic [ADDRBITS2-1:0] srcdst_w,
    input  logic [HOPBITS-1:0]   hop_n,
    input  logic [HOPBITS-1:0]   hop_s,
    input  logic [HOPBITS-1:0]   hop_e,
    input  logic [HOPBITS-1:0]   hop_w,
    input  logic                 inj_req,
    input  logic [ADDRBITS2-1:0] srcdst_i,
    output logic [4:0]           ctln,
    output logic [4:0]           ctls,
    output logic [4:0]           ctle,
    output logic [4:0]           ctlw,
    output logic [4:0]           ctli,
    output logic                 inj_gnt,
    output logic                 starve
);

    localparam int CNTW = $clog2(STARVE_LIM + 1);

    logic [3:0]           w_vld;
    logic [ADDRBITS2-1:0] w_sd  [4];
    logic [HOPBITS-1:0]   w_hop [4];
    port_t                w_prod[4];
    port_t                w_prod_inj;
    logic [1:0]           w_pos [4];
    logic [2:0]           w_rank[4];
    logic [HOPBITS-1:0]   w_max;
    logic [2:0]           w_ntop;
    port_t                w_free;
    port_t                w_pick;
    port_t                w_ctl [5];
    logic                 w_gnt;
    logic [CNTW-1:0]      w_cnt_nxt;
    logic                 w_unused;

    port_t                r_ctl [5];
    logic                 r_gnt;
    logic                 r_starve;
    logic [1:0]           r_rr;
    logic [CNTW-1:0]      r_cnt;

    assign w_vld = {vld_w, vld_e, vld_s, vld_n};
    assign w_sd  = '{srcdst_n, srcdst_s, srcdst_e, srcdst_w};
    assign w_hop = '{hop_n, hop_s, hop_e, hop_w};

    assign w_unused = ^{srcdst_n[ADDRBITS2-1:ADDRBITS2/2], srcdst_s[ADDRBITS2-1:ADDRBITS2/2],
                        srcdst_e[ADDRBITS2-1:ADDRBITS2/2], srcdst_w[ADDRBITS2-1:ADDRBITS2/2],
                        srcdst_i[ADDRBITS2-1:ADDRBITS2/2]};

    for (genvar g = 0; g < 4; g++) begin : g_rc
        bless_route_calc #(.ADDRBITS2(ADDRBITS2), .MY_X(MY_X), .MY_Y(MY_Y)) u_rc (
            .i_dst  (w_sd[g][ADDRBITS2/2-1:0]),
            .o_port (w_prod[g])
        );
    end

    bless_route_calc #(.ADDRBITS2(ADDRBITS2), .MY_X(MY_X), .MY_Y(MY_Y)) u_rc_inj (
        .i_dst  (srcdst_i[ADDRBITS2/2-1:0]),
        .o_port (w_prod_inj)
    );

    // Rank = number of valid flits that beat this one (older, or same age and earlier from rr).
    always_comb begin
        w_max  = '0;
        w_ntop = '0;
        for (int i = 0; i < 4; i++) begin
            w_pos[i]  = 2'(i) - r_rr;
            w_rank[i] = '0;
            if (w_vld[i] && (w_hop[i] > w_max)) w_max = w_hop[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (w_vld[i] && (w_hop[i] == w_max)) w_ntop = w_ntop + 3'd1;
            for (int j = 0; j < 4; j++) begin
                if ((j != i) && w_vld[j] &&
                    ((w_hop[j] > w_hop[i]) || ((w_hop[j] == w_hop[i]) && (w_pos[j] < w_pos[i]))))
                    w_rank[i] = w_rank[i] + 3'd1;
            end
        end
    end

    always_comb begin
        w_free = 5'b11111;
        w_pick = '0;
        w_gnt  = 1'b0;
        for (int o = 0; o < 5; o++) w_ctl[o] = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (w_vld[i] && (w_rank[i] == 3'(k))) begin
                    w_pick = (|(w_free & w_prod[i])) ? w_prod[i] : first_free(w_free);
                    w_free = w_free & ~w_pick;
                    for (int o = 0; o < 5; o++) if (w_pick[o]) w_ctl[o][i] = 1'b1;
                end
            end
        end
        if (inj_req && (|w_free[3:0])) begin
            w_gnt  = 1'b1;
            w_pick = (|(w_free & w_prod_inj & 5'b01111)) ? w_prod_inj : first_free(w_free);
            for (int o = 0; o < 5; o++) if (w_pick[o]) w_ctl[o][P_I] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        if (inj_req && !w_gnt)
            w_cnt_nxt = (r_cnt == CNTW'(STARVE_LIM)) ? r_cnt : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < 5; o++) r_ctl[o] <= '0;
            r_gnt    <= 1'b0;
            r_starve <= 1'b0;
            r_rr     <= '0;
            r_cnt    <= '0;
        end else begin
            for (int o = 0; o < 5; o++) r_ctl[o] <= w_ctl[o];
            r_gnt    <= w_gnt;
            r_starve <= (w_cnt_nxt == CNTW'(STARVE_LIM));
            r_cnt    <= w_cnt_nxt;
            if (w_ntop >= 3'd2) r_rr <= r_rr + 2'd1;
        end
    end

    assign ctln    = r_ctl[P_N];
    assign ctls    = r_ctl[P_S];
    assign ctle    = r_ctl[P_E];
    assign ctlw    = r_ctl[P_W];
    assign ctli    = r_ctl[P_I];
    assign inj_gnt = r_gnt;
    assign starve  = r_starve;

endmodule

// File: tb/tb_bless_port_alloc.sv
// Scoreboard bench for bless_port_alloc at router (1,1): directed vectors, queued expectations.
module tb_bless_port_alloc;

    typedef struct packed {
        logic [4:0] n;
        logic [4:0] s;
        logic [4:0] e;
        logic [4:0] w;
        logic [4:0] i;
        logic       gnt;
        logic       st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld [4];
    logic [7:0] sd  [4];
    logic [7:0] hop [4];
    logic       inj_req;
    logic [7:0] srcdst_i;
    logic [4:0] ctln, ctls, ctle, ctlw, ctli;
    logic       inj_gnt, starve;

    exp_t  q[$];
    string nq[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    exp_t  mon_e, mon_got;
    string mon_nm;

    always #5 clk = ~clk;

    bless_port_alloc #(
        .HOPBITS(8), .ADDRBITS2(8), .MY_X(1), .MY_Y(1), .STARVE_LIM(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vld_n(vld[0]), .vld_s(vld[1]), .vld_e(vld[2]), .vld_w(vld[3]),
        .srcdst_n(sd[0]), .srcdst_s(sd[1]), .srcdst_e(sd[2]), .srcdst_w(sd[3]),
        .hop_n(hop[0]), .hop_s(hop[1]), .hop_e(hop[2]), .hop_w(hop[3]),
        .inj_req(inj_req), .srcdst_i(srcdst_i),
        .ctln(ctln), .ctls(ctls), .ctle(ctle), .ctlw(ctlw), .ctli(ctli),
        .inj_gnt(inj_gnt), .starve(starve)
    );

    function automatic logic [7:0] xy(input int x, input int y);
        return {4'h0, 2'(y), 2'(x)};
    endfunction

    function automatic exp_t mk(input logic [4:0] n, input logic [4:0] s, input logic [4:0] e,
                                input logic [4:0] w, input logic [4:0] i, input logic g,
                                input logic st);
        return '{n: n, s: s, e: e, w: w, i: i, gnt: g, st: st};
    endfunction

    task automatic set_net(input int p, input logic v, input logic [7:0] d, input logic [7:0] h);
        vld[p] = v;
        sd[p]  = d;
        hop[p] = h;
    endtask

    task automatic clr_net();
        for (int p = 0; p < 4; p++) set_net(p, 1'b0, 8'h00, 8'h00);
    endtask

    // Every flit wants e; ages n=5 s=9 e=2 w=7.
    task automatic heavy_traffic();
        set_net(0, 1'b1, xy(2, 1), 8'd5);
        set_net(1, 1'b1, xy(2, 1), 8'd9);
        set_net(2, 1'b1, xy(2, 1), 8'd2);
        set_net(3, 1'b1, xy(2, 1), 8'd7);
    endtask

    task automatic step(input exp_t e, input string nm);
        q.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_nm  = nq.pop_front();
            mon_got = '{n: ctln, s: ctls, e: ctle, w: ctlw, i: ctli, gnt: inj_gnt, st: starve};
            n_vec++;
            if (mon_got !== mon_e) begin
                n_miss++;
                $display("FAIL %s: got n=%b s=%b e=%b w=%b i=%b gnt=%b starve=%b, want n=%b s=%b e=%b w=%b i=%b gnt=%b starve=%b",
                         mon_nm, mon_got.n, mon_got.s, mon_got.e, mon_got.w, mon_got.i, mon_got.gnt,
                         mon_got.st, mon_e.n, mon_e.s, mon_e.e, mon_e.w, mon_e.i, mon_e.gnt, mon_e.st);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e_zero, e_heavy;
        e_zero  = '0;
        e_heavy = mk(5'b01000, 5'b00001, 5'b00010, 5'b00100, 5'b00000, 1'b0, 1'b0);

        rst_n    = 1'b0;
        inj_req  = 1'b0;
        srcdst_i = 8'h00;
        clr_net();
        step(e_zero, "reset0");
        step(e_zero, "reset1");
        rst_n = 1'b1;

        set_net(0, 1'b1, xy(2, 1), 8'd3);
        set_net(1, 1'b0, xy(1, 1), 8'hFF);
        step(mk(5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0, 1'b0), "single_e");

        clr_net();
        heavy_traffic();
        step(e_heavy, "hop_order");

        clr_net();
        set_net(0, 1'b1, xy(1, 1), 8'd4);
        set_net(2, 1'b1, xy(1, 1), 8'd6);
        step(mk(5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0, 1'b0), "eject_oldest");

        clr_net();
        set_net(1, 1'b1, xy(1, 2), 8'd7);
        set_net(2, 1'b1, xy(1, 1), 8'd6);
        set_net(3, 1'b1, xy(1, 1), 8'd4);
        step(mk(5'b00010, 5'b01000, 5'b00000, 5'b00000, 5'b00100, 1'b0, 1'b0), "eject_defl_s");

        clr_net();
        set_net(0, 1'b1, xy(2, 1), 8'd4);
        set_net(1, 1'b1, xy(2, 1), 8'd4);
        step(mk(5'b00010, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0, 1'b0), "tie_rr0");
        step(mk(5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 1'b0, 1'b0), "tie_rr1");

        // rr is now 2 and favours n on a tie; s is older and must still win.
        clr_net();
        set_net(0, 1'b1, xy(2, 1), 8'hFE);
        set_net(1, 1'b1, xy(2, 1), 8'hFF);
        step(mk(5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 1'b0, 1'b0), "hop_ones_oldest");

        clr_net();
        inj_req  = 1'b1;
        srcdst_i = xy(1, 0);
        step(mk(5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0), "inj_prod_s");
        srcdst_i = xy(1, 1);
        step(mk(5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0), "inj_local_defl");

        heavy_traffic();
        srcdst_i = xy(2, 1);
        repeat (5) step(e_heavy, "blocked_pre");

        rst_n = 1'b0;
        step(e_zero, "mid_reset");
        rst_n = 1'b1;

        for (int k = 1; k <= 17; k++) begin
            exp_t ek;
            ek    = e_heavy;
            ek.st = (k >= 16);
            step(ek, $sformatf("starve_cnt%0d", k));
        end

        set_net(3, 1'b0, xy(2, 1), 8'd7);
        step(mk(5'b00001, 5'b00100, 5'b00010, 5'b10000, 5'b00000, 1'b1, 1'b0), "inj_grant");

        inj_req = 1'b0;
        clr_net();
        set_net(0, 1'b1, xy(2, 1), 8'd4);
        set_net(1, 1'b1, xy(2, 1), 8'd4);
        step(mk(5'b00010, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0, 1'b0), "tie_after_rst");

        clr_net();
        step(e_zero, "idle");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bless_port_alloc.md
BLESS_PORT_ALLOC -- requirements
Module: bless_port_alloc

Interface
REQ-001 Parameter HOPBITS, default 8, hop-count (age) width.
REQ-002 Parameter ADDRBITS2, default 8, packed {src,dst} width; dst = low ADDRBITS2/2 bits as {y,x}, each ADDRBITS2/4 bits.
REQ-003 Parameter MY_X, default 0, this router's x coordinate.
REQ-004 Parameter MY_Y, default 0, this router's y coordinate.
REQ-005 Parameter STARVE_LIM, default 16, consecutive blocked-injection cycles before starve asserts.
REQ-006 Clocking: one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 vld_n/s/e/w  in  1 each  network flit present on input port.
REQ-010 srcdst_n/s/e/w  in  ADDRBITS2 each  flit {src,dst}.
REQ-011 hop_n/s/e/w  in  HOPBITS each  flit age.
REQ-012 inj_req  in  1  local core requests injection on port i.
REQ-013 ctln, ctls, ctle, ctlw, ctli  out  5 each  one-hot input select per output; bit0=n, 1=s, 2=e, 3=w, 4=i; all-zero = output idle.
REQ-014 inj_gnt  out  1  injection flit accepted this cycle.
REQ-015 starve  out  1  injection starvation flag.

Function
REQ-016 Inputs are sampled at a rising edge; ctl*, inj_gnt and starve are registered and valid the following cycle (latency 1), aligned with the crossbar datapath register.
REQ-017 Productive port (XY): dst_x>MY_X -> e; dst_x<MY_X -> w; else dst_y>MY_Y -> n; dst_y<MY_Y -> s; else eject (output i).
REQ-018 Network flits are allocated in descending hop order; equal hop is ordered by a rotating pointer rr (0..3 = n,s,e,w), starting at rr and wrapping.
REQ-019 Each flit takes its productive port if free; otherwise it is deflected to the first free of n,s,e,w in that fixed order.
REQ-020 Output i carries at most one flit per cycle; further local-destined flits are deflected per REQ-019.
REQ-021 Every valid network flit always receives exactly one output; no drop, no duplicate, no output driven by two inputs.
REQ-022 Injection is allocated last: inj_gnt=1 iff inj_req=1 and at least one of n,s,e,w remains free; the injected flit takes its productive port if free, else first free per REQ-019; injected flits never use output i.
REQ-023 rr advances by 1 (mod 4) in every cycle in which two or more valid network flits share the highest hop value; otherwise it holds.
REQ-024 Starvation counter increments each cycle inj_req=1 and inj_gnt=0, saturating at STARVE_LIM; clears on grant or inj_req=0.
REQ-025 starve=1 while counter equals STARVE_LIM; it deasserts the cycle after the counter clears.
REQ-026 Inputs with vld=0 are ignored regardless of srcdst/hop contents.
REQ-027 hop=all-ones compares as the oldest value; no wrap arithmetic is performed (hop increment is done in the datapath).

Reset
REQ-028 While rst_n=0 at a clock edge: all ctl* = 0, inj_gnt = 0, starve = 0, rr = 0, starvation counter = 0.
REQ-029 Reset asserted mid-operation discards the in-flight allocation; the first allocation after release uses inputs sampled on the first edge with rst_n=1.

Structure
REQ-030 Shared package bless_alloc_pkg holds port-index constants (P_N=0..P_I=4), the 5-bit one-hot port type, and the XY route function.
REQ-031 One sub-module, bless_route_calc, computes the productive port from dst and MY_X/MY_Y; instantiated once per network input plus once for injection.
REQ-032 Allocation is purely combinational into one register stage; no multi-cycle FSM.

Verification
REQ-033 MY=(1,1); vld_n only, dst (2,1), hop 3 -> next cycle ctle=00001, all other ctl=0.
REQ-034 All four valid, every dst (2,1), hops n=5, s=9, e=2, w=7 -> ctle=00010 (s), others deflected: w->n, n->s, e->w.
REQ-035 Two flits dst (1,1), hops 4 and 6 -> ctli selects the hop-6 input; the other is deflected to n (or s if n is taken).
REQ-036 Four valid network flits none local, inj_req=1 -> inj_gnt=0 and ctli=0; hold for 16 cycles -> starve=1 on 16th blocked cycle; then one input idle -> inj_gnt=1, starve=0 the cycle after.
REQ-037 n and s valid, equal hop 4, both dst e, rr=0 -> n gets e, rr becomes 1; repeat -> s gets e.
REQ-038 rst_n=0 during REQ-034 traffic -> all outputs 0 next cycle; rr and counter 0 after release.
